cc_deserializer: RTL and testbench

Collects a burst of eight 64-bit read-data beats from the memory-side read channel into one 512-bit cache line. Tags the line with a 6-bit line header and pushes it as a single 518-bit word into the refill FIFO toward the cache controller. It is the receive-side counterpart of the line serializer: the word layout it produces is the layout the serializer consumes. It runs one line at a time and supports a critical-word-first (wrapping) burst order.

---
 rtl/cc_deserializer.sv | 81 ++++++++
 tb/tb_cc_deserializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cc_deserializer.sv
// Gathers eight 64-bit read beats into a 512-bit cache line and pushes {header, line}
// as one 518-bit word into the refill FIFO; supports critical-word-first bursts.
module cc_deserializer (
    input  logic         clk,
    input  logic         rst,
    input  logic         hdr_valid_i,
    input  logic [5:0]   hdr_i,
    output logic         hdr_ready_o,
    input  logic [63:0]  rdata_i,
    input  logic         rlast_i,
    input  logic         rvalid_i,
    output logic         rready_o,
    input  logic         fifo_full_i,
    output logic         fifo_wren_o,
    output logic [517:0] fifo_wdata_o,
    output logic         err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUSH    = 2'd2
    } state_t;

    state_t       state;
    logic [5:0]   hdr;
    logic [511:0] line;
    logic [2:0]   idx;
    logic [2:0]   cnt;
    logic         err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            hdr   <= 6'd0;
            line  <= 512'd0;
            idx   <= 3'd0;
            cnt   <= 3'd0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (hdr_valid_i) begin
                        hdr   <= hdr_i;
                        idx   <= hdr_i[2:0];
                        cnt   <= 3'd0;
                        state <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (rvalid_i) begin
                        // Slot 0 is the most significant word of the line
                        for (int k = 0; k < 8; k++) begin
                            if (idx == 3'(k))
                                line[511-64*k -: 64] <= rdata_i;
                        end
                        idx <= idx + 3'd1;
                        cnt <= cnt + 3'd1;
                        if ((rlast_i && cnt != 3'd7) || (!rlast_i && cnt == 3'd7))
                            err <= 1'b1;
                        if (rlast_i || cnt == 3'd7)
                            state <= PUSH;
                    end
                end
                PUSH: begin
                    if (!fifo_full_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hdr_ready_o  = (state == IDLE);
    assign rready_o     = (state == COLLECT);
    assign fifo_wren_o  = (state == PUSH) && !fifo_full_i;
    assign fifo_wdata_o = {hdr, line};
    assign err_o        = err;

endmodule

// File: tb/tb_cc_deserializer.sv
// Directed bench for cc_deserializer: a slot-array model predicts every FIFO word and
// error pulse; a per-cycle monitor compares pushes and err_o against it.
module tb_cc_deserializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         hdr_valid;
    logic [5:0]   hdr;
    logic         hdr_ready;
    logic [63:0]  rdata;
    logic         rlast;
    logic         rvalid;
    logic         rready;
    logic         fifo_full;
    logic         fifo_wren;
    logic [517:0] fifo_wdata;
    logic         err;

    cc_deserializer dut (
        .clk          (clk),
        .rst          (rst),
        .hdr_valid_i  (hdr_valid),
        .hdr_i        (hdr),
        .hdr_ready_o  (hdr_ready),
        .rdata_i      (rdata),
        .rlast_i      (rlast),
        .rvalid_i     (rvalid),
        .rready_o     (rready),
        .fifo_full_i  (fifo_full),
        .fifo_wren_o  (fifo_wren),
        .fifo_wdata_o (fifo_wdata),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_cyc = -1;
    int rd = 0;

    // Model state: slot contents, header, burst start and beats seen so far
    logic [63:0]  m_line [8];
    logic [5:0]   m_hdr;
    int           m_start;
    int           m_n;
    logic [517:0] exp_q [$];
    logic [517:0] last_push;
    logic [517:0] snap;

    task automatic chk(input string name, input logic [517:0] act, input logic [517:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [517:0] model_word();
        logic [517:0] w;
        w = '0;
        w[517:512] = m_hdr;
        for (int k = 0; k < 8; k++)
            w[511-64*k -: 64] = m_line[k];
        return w;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        chk("err_o", {517'd0, err}, {517'd0, (cyc == err_cyc)});
        if (fifo_wren) begin
            chk("wren_gated", {517'd0, fifo_full}, 518'd0);
            if (rd < exp_q.size())
                chk("push_data", fifo_wdata, exp_q[rd]);
            else
                chk("push_unexpected", {517'd0, fifo_wren}, 518'd0);
            last_push = fifo_wdata;
            rd++;
        end
    end

    // All tasks start and end just after a falling edge
    task automatic send_hdr(input logic [5:0] h);
        int t = 0;
        hdr_valid = 1'b1;
        hdr = h;
        while (!hdr_ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("hdr_ready_wait", {517'd0, hdr_ready}, 518'd1);
        @(posedge clk);
        #1;
        m_hdr = h;
        m_start = int'(h[2:0]);
        m_n = 0;
        @(negedge clk);
        hdr_valid = 1'b0;
        chk("rready_after_hdr", {517'd0, rready}, 518'd1);
        chk("hdr_ready_collect", {517'd0, hdr_ready}, 518'd0);
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input int gap);
        int t = 0;
        bit term, bad;
        rvalid = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            chk("hdr_ready_gap", {517'd0, hdr_ready}, 518'd0);
        end
        rvalid = 1'b1;
        rdata = d;
        rlast = last;
        while (!rready && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("rready_wait", {517'd0, rready}, 518'd1);
        @(posedge clk);
        #1;
        m_line[(m_start + m_n) % 8] = d;
        term = (m_n == 7) || last;
        bad = (last && m_n < 7) || (!last && m_n == 7);
        m_n++;
        if (bad) err_cyc = cyc;
        if (term) exp_q.push_back(model_word());
        @(negedge clk);
        rvalid = 1'b0;
        rlast = 1'b0;
    endtask

    task automatic send_line(input logic [5:0] h, input logic [63:0] base, input int n,
                             input int last_at, input int gap);
        send_hdr(h);
        for (int b = 0; b < n; b++)
            send_beat(base + 64'(b), (b == last_at), gap);
        chk("wren_latency", {517'd0, fifo_wren}, 518'd1);
        @(negedge clk);
        chk("idle_again", {517'd0, hdr_ready}, 518'd1);
        chk("rready_idle", {517'd0, rready}, 518'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++) m_line[k] = 64'd0;
        rst = 1'b1; hdr_valid = 1'b0; hdr = 6'd0; rdata = 64'd0;
        rlast = 1'b0; rvalid = 1'b0; fifo_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_hdr_ready", {517'd0, hdr_ready}, 518'd1);
        chk("rst_rready", {517'd0, rready}, 518'd0);
        chk("rst_wren", {517'd0, fifo_wren}, 518'd0);
        chk("rst_wdata", fifo_wdata, 518'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic line, start offset 0
        send_line(6'b000000, 64'd1, 8, 7, 0);
        chk("basic_slot0", {454'd0, last_push[511:448]}, 518'd1);
        chk("basic_slot7", {454'd0, last_push[63:0]}, 518'd8);
        chk("basic_hdr", {512'd0, last_push[517:512]}, 518'd0);

        // Early rlast on 5th beat; slots 5..7 keep 6,7,8
        send_line(6'b000000, 64'd9, 5, 4, 0);
        chk("early_slot0", {454'd0, last_push[511:448]}, 518'd9);
        chk("early_slot4", {454'd0, last_push[255:192]}, 518'd13);
        chk("early_slot5", {454'd0, last_push[191:128]}, 518'd6);
        chk("early_slot7", {454'd0, last_push[63:0]}, 518'd8);

        // Wrapping burst starting at slot 3
        send_line(6'b010011, 64'd1, 8, 7, 0);
        chk("wrap_slot0", {454'd0, last_push[511:448]}, 518'd6);
        chk("wrap_slot3", {454'd0, last_push[319:256]}, 518'd1);
        chk("wrap_hdr", {512'd0, last_push[517:512]}, 518'd19);

        // Backpressure: gapped beats, FIFO full for first 3 PUSH cycles
        send_hdr(6'b000101);
        for (int b = 0; b < 7; b++) send_beat(64'h40 + 64'(b), 1'b0, 1);
        fifo_full = 1'b1;
        send_beat(64'h47, 1'b1, 1);
        snap = model_word();
        for (int i = 0; i < 3; i++) begin
            chk("bp_wren_low", {517'd0, fifo_wren}, 518'd0);
            chk("bp_wdata_hold", fifo_wdata, snap);
            chk("bp_hdr_ready", {517'd0, hdr_ready}, 518'd0);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        fifo_full = 1'b0;
        @(negedge clk);
        chk("bp_wren_high", {517'd0, fifo_wren}, 518'd1);
        chk("bp_wdata", fifo_wdata, snap);
        @(negedge clk);
        chk("bp_single_pulse", {517'd0, fifo_wren}, 518'd0);
        chk("bp_idle", {517'd0, hdr_ready}, 518'd1);

        // Stray beats in IDLE, then a burst with no rlast
        rvalid = 1'b1;
        rdata = 64'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_rready", {517'd0, rready}, 518'd0);
        end
        rvalid = 1'b0;
        send_line(6'b000010, 64'h20, 8, -1, 0);
        chk("late_slot2", {454'd0, last_push[383:320]}, 518'h20);

        // Reset after four beats discards the partial line and clears the buffer
        send_hdr(6'b000001);
        for (int b = 0; b < 4; b++) send_beat(64'h70 + 64'(b), 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_hdr_ready", {517'd0, hdr_ready}, 518'd1);
        chk("mid_rst_rready", {517'd0, rready}, 518'd0);
        chk("mid_rst_wren", {517'd0, fifo_wren}, 518'd0);
        chk("mid_rst_wdata", fifo_wdata, 518'd0);
        for (int k = 0; k < 8; k++) m_line[k] = 64'd0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {517'd0, hdr_ready}, 518'd1);
        send_line(6'b100101, 64'h100, 8, 7, 0);
        chk("post_rst_slot5", {454'd0, last_push[191:128]}, 518'h100);

        repeat (3) @(negedge clk);
        chk("push_count", 518'(rd), 518'(exp_q.size()));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
